// File: rtl/mat_exec_pkg.sv
// mat_exec_pkg: shared constants, state encoding and element addressing for mat_exec_unit
// Contents: ELEM_W/DIM/WORD_W sizes, OP_* opcodes, state_t, elem_off() bit offset of element (r,c)
package mat_exec_pkg;
  localparam int ELEM_W = 16;
  localparam int DIM = 4;
  localparam int WORD_W = DIM * DIM * ELEM_W;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_TRANS = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_SCALE = 3'd4;
  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_WRITE, S_ERR} state_t;
  function automatic int elem_off(input int r, input int c);
    return ELEM_W * (DIM * r + c);
  endfunction
endpackage

// File: rtl/mat_exec_unit_dot4.sv
// mat_dot4: combinational row-by-column dot product, truncated to ELEM_W
// Ports: row (DIM elements of A row), col (DIM elements of B column), dot (low ELEM_W bits of the sum)
module mat_dot4
  import mat_exec_pkg::*;
(
  input  logic [DIM*ELEM_W-1:0] row,
  input  logic [DIM*ELEM_W-1:0] col,
  output logic [ELEM_W-1:0]     dot
);
  logic [2*ELEM_W-1:0] acc;
  always_comb begin
    acc = '0;
    for (int k = 0; k < DIM; k++)
      acc = acc + 32'(row[k*ELEM_W +: ELEM_W]) * 32'(col[k*ELEM_W +: ELEM_W]);
  end
  assign dot = acc[ELEM_W-1:0];
endmodule

// File: rtl/mat_exec_unit.sv
// mat_exec_unit: multi-cycle 4x4 matrix ADD/SUB/TRANSPOSE/MUL(/SCALE) stage feeding the data_mem write port
// Ports: clk, reset (async active-low); start/op/dest_ptr/scalar/opnd_a/opnd_b request captured in IDLE;
//        busy/done/err status; wr_en/wr_ptr/wr_data registered data_mem write port.
// Build option: define MAT_EXEC_SCALE_EN to make opcode 4 (SCALE) legal; otherwise it takes the error path.
module mat_exec_unit
  import mat_exec_pkg::*;
#(
  parameter int PTR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [PTR_W-1:0]  dest_ptr,
  input  logic [ELEM_W-1:0] scalar,
  input  logic [WORD_W-1:0] opnd_a,
  input  logic [WORD_W-1:0] opnd_b,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wr_en,
  output logic [PTR_W-1:0]  wr_ptr,
  output logic [WORD_W-1:0] wr_data
);
  state_t state, nxt;
  logic [2:0] op_q;
  logic [PTR_W-1:0] dest_q;
  logic [ELEM_W-1:0] scalar_q, dot;
  logic [WORD_W-1:0] a_q, b_q, result, ew;
  logic [DIM*ELEM_W-1:0] col;
  logic [3:0] idx;
  logic legal;
  int mr, mc;
  mat_dot4 u_dot (.row(a_q[elem_off(mr, 0) +: DIM*ELEM_W]), .col(col), .dot(dot));
  always_comb begin
    legal = op < OP_SCALE;
`ifdef MAT_EXEC_SCALE_EN
    legal = legal | (op == OP_SCALE);
`endif
    nxt = state == S_IDLE ? (start ? (!legal ? S_ERR : op == OP_MUL ? S_MUL : S_EXEC) : S_IDLE)
        : state == S_EXEC ? S_WRITE
        : state == S_MUL ? (idx == 4'd15 ? S_WRITE : S_MUL)
        : S_IDLE;
  end
  // elementwise result, evaluated on the captured operands
  always_comb begin
    ew = '0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        ew[elem_off(r, c) +: ELEM_W] =
          op_q == OP_ADD ? a_q[elem_off(r, c) +: ELEM_W] + b_q[elem_off(r, c) +: ELEM_W]
        : op_q == OP_SUB ? a_q[elem_off(r, c) +: ELEM_W] - b_q[elem_off(r, c) +: ELEM_W]
        : a_q[elem_off(c, r) +: ELEM_W];
`ifdef MAT_EXEC_SCALE_EN
        if (op_q == OP_SCALE) ew[elem_off(r, c) +: ELEM_W] = a_q[elem_off(r, c) +: ELEM_W] * scalar_q;
`endif
      end
  end
  // MUL walks idx row-major; gather column mc of B for the shared dot product
  always_comb begin
    mr = int'(idx[3:2]);
    mc = int'(idx[1:0]);
    col = '0;
    for (int k = 0; k < DIM; k++) col[k*ELEM_W +: ELEM_W] = b_q[elem_off(k, mc) +: ELEM_W];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      op_q <= '0;
      dest_q <= '0;
      scalar_q <= '0;
      a_q <= '0;
      b_q <= '0;
      idx <= '0;
      result <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      wr_en <= 1'b0;
      wr_ptr <= '0;
      wr_data <= '0;
    end else begin
      state <= nxt;
      busy <= state != S_IDLE;
      done <= state == S_WRITE || state == S_ERR;
      err <= state == S_ERR;
      wr_en <= state == S_WRITE;
      if (state == S_IDLE && start) begin
        op_q <= op;
        dest_q <= dest_ptr;
        scalar_q <= scalar;
        a_q <= opnd_a;
        b_q <= opnd_b;
        idx <= '0;
      end
      if (state == S_EXEC) result <= ew;
      if (state == S_MUL) begin
        result[elem_off(mr, mc) +: ELEM_W] <= dot;
        idx <= idx + 4'd1;
      end
      if (state == S_WRITE) begin
        wr_ptr <= dest_q;
        wr_data <= result;
      end
    end
endmodule

// File: doc/mat_exec_unit.md
# mat_exec_unit

Multi-cycle 4x4 matrix execution stage sitting directly downstream of `data_mem`. Consumes the two 256-bit read-port operands (`data1`/`data2`), computes a matrix result, and drives the `data_mem` write port (`write_data`, `write_data_pointer`, `data_to_write`) with the result. A matrix word is 16 elements of 16 bits; element (r,c) occupies bits [16*(4r+c)+15 : 16*(4r+c)].

## Interface
- `ELEM_W`, 16, element width in bits
- `DIM`, 4, matrix dimension (word = DIM*DIM*ELEM_W = 256)
- `PTR_W`, 3, `data_mem` pointer width
- `clk` in 1, rising-edge clock
- `reset` in 1, asynchronous, active-low reset
- `start` in 1, request; sampled only in IDLE
- `op` in 3, opcode, captured with `start`
- `dest_ptr` in PTR_W, destination pointer, captured with `start`
- `scalar` in ELEM_W, SCALE multiplier, captured with `start`
- `opnd_a` in 256, operand A (from `data1`), captured with `start`
- `opnd_b` in 256, operand B (from `data2`), captured with `start`
- `busy` out 1, high from the cycle after accept through the WRITE/ERR cycle
- `done` out 1, one-cycle completion pulse
- `err` out 1, one-cycle pulse with `done` on illegal opcode
- `wr_en` out 1, drives `data_mem` write strobe
- `wr_ptr` out PTR_W, drives `data_mem` write pointer
- `wr_data` out 256, drives `data_mem` write data

## Operation
- Opcodes: 0 ADD (A+B), 1 SUB (A−B), 2 TRANSPOSE (Aᵀ, B ignored), 3 MUL (A×B), 4 SCALE (A·scalar, config-gated), 5–7 illegal.
- States: IDLE, EXEC, MUL, WRITE, ERR.
- IDLE: `start`=1 → capture operands/op/dest; legal elementwise op → EXEC; MUL → MUL with idx=0; illegal → ERR.
- EXEC: full 256-bit result registered in one cycle → WRITE.
- MUL: one result element per cycle, idx 0..15 (r=idx/4, c=idx%4), element = Σk A(r,k)·B(k,c); idx=15 → WRITE.
- WRITE: `wr_en`=1, `wr_ptr`=dest, `wr_data`=result, `done`=1 for one cycle → IDLE.
- ERR: `done`=1, `err`=1, `wr_en`=0 for one cycle → IDLE.
- Arithmetic: all element results modulo 2^16 (truncate; no saturation, no flags). MUL: four 32-bit products summed, low 16 bits kept.
- `start` outside IDLE (including WRITE/ERR cycle) is ignored; not queued.

## Timing
- Reset (async assert, sync release): state IDLE, idx 0, result 0; `busy`,`done`,`err`,`wr_en`=0, `wr_ptr`=0, `wr_data`=0.
- Accept at edge N. ADD/SUB/TRANSPOSE/SCALE: `wr_en`/`done` high during cycle N+2→N+3 (latency 2). MUL: high during N+17→N+18 (latency 17). Illegal: `done`/`err` during N+1→N+2.
- Earliest next accept: edge following the WRITE/ERR cycle.
- `wr_data`/`wr_ptr` are registered, stable while `wr_en`=1; `wr_en` is zero outside WRITE.
- Reset mid-operation: operation abandoned, no write issued.

## Configuration
- `MAT_EXEC_SCALE_EN` defined: opcode 4 performs SCALE, latency 2.
- Undefined: opcode 4 is illegal (ERR path), no multiplier for SCALE is synthesized.

## Structure
- Package `mat_exec_pkg`: opcode constants, state enum, `ELEM_W`/`DIM` localparams, element bit-offset function.
- Sub-module `mat_dot4`: combinational 4-element row·column dot product (truncated to ELEM_W), instantiated once for MUL.

## Test plan
- ADD: A all 0x0001, B element i = i, dest 5 → at N+2 `wr_en`=1, `wr_ptr`=5, element i = i+1, `done`=1.
- SUB wrap: A all 0x0000, B all 0x0001 → all elements 0xFFFF.
- TRANSPOSE: A(r,c)=4r+c → result(r,c)=4c+r; B=random has no effect.
- MUL: A(r,c)=4r+c, B=identity → result==A, `wr_en` at N+17, `busy` high N+1..N+17; A=all 0x0100, B=all 0x0100 → all 0x0000 (wrap).
- Illegal op 7 (and op 4 with `MAT_EXEC_SCALE_EN` undefined) → `done`=`err`=1 at N+1, `wr_en` never asserted; with macro defined, op 4 scalar 3 on A all 0x0002 → all 0x0006.
- `start` pulsed during MUL idx 5 ignored; `reset` low at idx 8 → all outputs 0 immediately, no `wr_en`; fresh ADD after release completes normally.
